// File: rtl/muldiv_sequencer.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// Shift-add multiply, restoring divide, sign fix-up in a final cycle.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    input  logic             hilo_read,
    output logic             busy,
    output logic             pause,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state, state_nx;
    logic [1:0]         op_q;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b, orig_a;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;

    logic               accept;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ok;
    logic [WIDTH-1:0]   rem_nx;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   res_hi, res_lo;

    assign busy   = (state != IDLE);
    assign pause  = hilo_read & (busy | start);
    assign accept = (state == IDLE) & start & ~flush;

    // Signed ops work on magnitudes; the signs are restored in FIX.
    always_comb begin
        abs_a = operand_a;
        abs_b = operand_b;
        if (!op[0] && operand_a[WIDTH-1]) abs_a = -operand_a;
        if (!op[0] && operand_b[WIDTH-1]) abs_b = -operand_b;
    end

    // One iteration of multiply or divide, plus the final fix-up values.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + (mag_b[0] ? {1'b0, mag_a} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], mag_a[WIDTH-1]};
        div_ok    = (div_shift >= {1'b0, mag_b});
        rem_nx    = div_shift[WIDTH-1:0];
        if (div_ok) rem_nx = div_shift[WIDTH-1:0] - mag_b;

        prod = acc;
        if (!op_q[0] && (neg_a ^ neg_b)) prod = -acc;
        quo = acc[WIDTH-1:0];
        rem = acc[2*WIDTH-1:WIDTH];
        if (!op_q[0] && (neg_a ^ neg_b)) quo = -acc[WIDTH-1:0];
        if (!op_q[0] && neg_a) rem = -acc[2*WIDTH-1:WIDTH];

        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (op_q[1]) begin
            res_hi = rem;
            res_lo = quo;
            if (div_by_zero) begin
                res_hi = orig_a;
                res_lo = '1;
            end
        end
    end

    // Next-state logic; flush always wins over progress.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = CALC;
            CALC: begin
                if (flush) state_nx = IDLE;
                else if (count == LAST) state_nx = FIX;
            end
            FIX:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State, operand, accumulator and HI/LO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            op_q        <= '0;
            neg_a       <= 1'b0;
            neg_b       <= 1'b0;
            mag_a       <= '0;
            mag_b       <= '0;
            orig_a      <= '0;
            acc         <= '0;
            count       <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q        <= op;
                        neg_a       <= operand_a[WIDTH-1];
                        neg_b       <= operand_b[WIDTH-1];
                        mag_a       <= abs_a;
                        mag_b       <= abs_b;
                        orig_a      <= operand_a;
                        div_by_zero <= op[1] & (operand_b == '0);
                        acc         <= '0;
                        count       <= '0;
                    end
                end
                CALC: begin
                    if (!flush) begin
                        count <= count + 1'b1;
                        if (op_q[1]) begin
                            acc   <= {rem_nx, acc[WIDTH-2:0], div_ok};
                            mag_a <= mag_a << 1;
                        end else begin
                            acc   <= {mul_sum, acc[WIDTH-1:1]};
                            mag_b <= mag_b >> 1;
                        end
                    end
                end
                FIX: begin
                    if (!flush) begin
                        hi   <= res_hi;
                        lo   <= res_lo;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer.
// Random and directed ops against an arithmetic reference model.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a, operand_b;
    logic        flush;
    logic        hilo_read;
    logic        busy, pause, done, div_by_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(.WIDTH(32), .ITER(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .flush(flush), .hilo_read(hilo_read),
        .busy(busy), .pause(pause), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [1:0] o,
                                  input logic [31:0] a, b,
                                  output logic [31:0] eh, el,
                                  output logic ed);
        longint sa, sb, p, q, r;
        longint unsigned ua, ub, up, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ed = o[1] && (b == 32'd0);
        eh = '0;
        el = '0;
        case (o)
            2'd0: begin
                p = sa * sb;
                eh = p[63:32];
                el = p[31:0];
            end
            2'd1: begin
                up = ua * ub;
                eh = up[63:32];
                el = up[31:0];
            end
            2'd2: begin
                if (b == 32'd0) begin
                    eh = a;
                    el = 32'hFFFF_FFFF;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    eh = r[31:0];
                    el = q[31:0];
                end
            end
            default: begin
                if (b == 32'd0) begin
                    eh = a;
                    el = 32'hFFFF_FFFF;
                end else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    eh = ur[31:0];
                    el = uq[31:0];
                end
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Entered and left at posedge+1. Issues one op and follows it to done.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, b,
                         input bit hr, input bit intr);
        logic [31:0] eh, el;
        logic        ed;
        int          n;
        bit          bad_pause;
        model(o, a, b, eh, el, ed);
        start = 1'b1;
        op = o;
        operand_a = a;
        operand_b = b;
        hilo_read = hr;
        @(negedge clk);
        check("pause_accept", pause, hr);
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        bad_pause = 0;
        while (n < 40) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (hr && !pause) bad_pause = 1;
            if (n == 1) check("dbz_at_accept", div_by_zero, ed);
            if (intr && n == 5) begin
                start = 1'b1;
                op = ~o;
                operand_a = $urandom;
                operand_b = $urandom;
            end
            if (intr && n == 6) start = 1'b0;
        end
        check("busy_cycles", n, 33);
        if (hr) check("pause_busy", bad_pause, 0);
        check("done_pulse", done, 1'b1);
        check("pause_done", pause, 1'b0);
        check("hi", hi, eh);
        check("lo", lo, el);
        check("dbz", div_by_zero, ed);
        @(posedge clk);
        #1 hilo_read = 1'b0;
        @(negedge clk);
        check("done_once", done, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        hilo_read = 1'b1;
        op = '0;
        operand_a = '0;
        operand_b = '0;
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_dbz", div_by_zero, 1'b0);
        check("pause_idle", pause, 1'b0);
        hilo_read = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
        check("multu_max_hi", hi, 32'hFFFF_FFFE);
        check("multu_max_lo", lo, 32'h0000_0001);
        do_op(2'd0, 32'hFFFF_FFFD, 32'd5, 0, 0);
        check("mult_neg_hi", hi, 32'hFFFF_FFFF);
        check("mult_neg_lo", lo, 32'hFFFF_FFF1);
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);
        do_op(2'd3, 32'd10, 32'd0, 0, 0);
        check("divu0_lo", lo, 32'hFFFF_FFFF);
        check("divu0_hi", hi, 32'h0000_000A);
        check("divu0_dbz", div_by_zero, 1'b1);
        do_op(2'd1, 32'd2, 32'd3, 0, 0);
        check("multu23_lo", lo, 32'd6);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'd0);
        do_op(2'd2, 32'hFFFF_FF00, 32'd0, 1, 0);
        do_op(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1);

        for (int i = 0; i < 24; i++)
            do_op(2'($urandom_range(0, 3)), pick(), pick(),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        do_op(2'd3, 32'h5678_1234, 32'h0001_0000, 0, 0);
        check("pre_flush_hi", hi, 32'h0000_1234);
        check("pre_flush_lo", lo, 32'h0000_5678);

        start = 1'b1;
        flush = 1'b1;
        op = 2'd1;
        operand_a = 32'd7;
        operand_b = 32'd9;
        @(posedge clk);
        #1 start = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("flush_blocks_start", busy, 1'b0);
        @(posedge clk);
        #1;

        start = 1'b1;
        op = 2'd1;
        operand_a = $urandom;
        operand_b = $urandom;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("busy_before_flush", busy, 1'b1);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy", busy, 1'b0);
        check("flush_done", done, 1'b0);
        check("flush_hi", hi, 32'h0000_1234);
        check("flush_lo", lo, 32'h0000_5678);
        @(negedge clk);
        check("flush_no_done", done, 1'b0);
        @(posedge clk);
        #1;

        start = 1'b1;
        op = 2'd0;
        operand_a = 32'hDEAD_BEEF;
        operand_b = 32'h1357_9BDF;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        do_op(2'd0, 32'hFFFF_FFF0, 32'h0000_0100, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Iterative 32-bit multiply/divide unit with its own sequencing FSM and HI/LO registers, for the 5-stage pipeline. The EX stage issues MULT/MULTU/DIV/DIVU through a one-cycle start. The ID stage reports when the instruction it holds reads HI/LO (MFHI/MFLO). The block drives pause into the hazard unit to stall the front end while a result is still pending. An exception flush aborts an operation in flight.

Parameters:
WIDTH, 32, operand/result width. Fixed at 32 for MIPS HI/LO.
ITER, 32, iteration count. Must equal WIDTH.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  EX stage issues a mul/div op this cycle
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
operand_a  input  32  rs value; multiplicand or dividend
operand_b  input  32  rt value; multiplier or divisor
flush  input  1  exception flush; aborts the current op
hilo_read  input  1  ID-stage instruction reads HI or LO
busy  output  1  operation in flight
pause  output  1  stall request to the hazard unit
done  output  1  one-cycle pulse: HI/LO just updated
div_by_zero  output  1  last accepted DIV/DIVU had divisor 0
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, count=0, hi=lo=0, done=0, div_by_zero=0, all internal operand and accumulator registers 0.
- States: IDLE, CALC, FIX.
- busy = (state != IDLE). This is combinational from the state register.
- pause = hilo_read & (busy | start). This is combinational.
- Accept: at a rising edge in IDLE with start=1 and flush=0:
  - latch op and the sign flags of both operands;
  - latch |operand_a| and |operand_b| for signed ops, raw values for unsigned ops;
  - set div_by_zero = (op[1] & operand_b==0);
  - clear the accumulator, set count=0, go to CALC.
- start while busy: ignored, no queueing. Upstream must hold the instruction; pause does not cover this case.
- CALC: one iteration per edge, count 0..31. Go to FIX on the edge where count==31.
  - Multiply: shift-add over a 64-bit product on the magnitudes.
  - Divide: restoring shift-subtract. A 33-bit trial subtraction yields one quotient bit per cycle.
- FIX, one edge:
  - Signed MULT: negate the 64-bit product if the operand signs differ.
  - Signed DIV: negate the quotient if the signs differ; give the remainder the sign of the dividend.
  - Write hi = product[63:32] or remainder; lo = product[31:0] or quotient.
  - Set done=1 for the following cycle only, then return to IDLE.
- Divide by zero, signed or unsigned: still takes the full latency. FIX forces lo=0xFFFFFFFF and hi=original operand_a.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This is the natural result; no trap.
- Latency: HI/LO are updated 33 edges after the accepting edge.
  - busy is high for the 33 cycles between those edges.
  - done is high in the cycle after the update. busy=0 in that cycle, so a stalled MFHI/MFLO proceeds and reads the new value.
- flush=1 at any edge with busy=1: go to IDLE; hi, lo and div_by_zero unchanged; done stays 0. Flush has priority over FIX completion.
- flush=1 with start=1 in IDLE: the start is not accepted.
- div_by_zero holds its value until the next accepted start.
- An asynchronous reset mid-operation drops to reset values immediately.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, start at edge 0 -> busy for 33 cycles; hi=0xFFFFFFFE, lo=0x00000001 after edge 33; done high exactly one cycle.
- MULT 0xFFFFFFFD (-3) x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_by_zero=0.
- DIVU 10 / 0 -> lo=0xFFFFFFFF, hi=0x0000000A, div_by_zero=1 after edge 33. Then MULTU 2x3 -> div_by_zero clears at its accept; hi=0, lo=6.
- hilo_read=1 held from the accept cycle (start=1) onward -> pause=1 in the accept cycle and all 33 busy cycles; pause=0 in the done cycle. Also drive hilo_read=1 with busy=0 and start=0 -> pause=0.
- Flush at the 10th CALC cycle with prior hi/lo = 0x1234/0x5678 -> busy=0 next cycle; hi/lo still 0x1234/0x5678; no done pulse. start during busy -> ignored; the result matches the first op.
- reset=0 pulse mid-CALC, between clock edges -> busy, done and hi/lo go to 0 immediately. After release, a new start completes normally in 33 cycles.
